// File: rtl/pyramic_clkdiv_gen.sv
// Multi-channel integer clock/strobe divider with per-channel phase offset,
// common-epoch realignment and a settle-timed lock indication.
module pyramic_clkdiv_gen #(
  parameter int unsigned NUM_CLOCKS  = 4,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned SEL_W       = 2,
  parameter logic [NUM_CLOCKS*CNT_W-1:0] DIV_INIT   = {16'd8, 16'd4, 16'd2, 16'd2},
  parameter logic [NUM_CLOCKS*CNT_W-1:0] PHASE_INIT = {16'd0, 16'd0, 16'd1, 16'd0},
  parameter int unsigned LOCK_CYCLES = 16
) (
  input  logic                  refclk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  resync,
  input  logic                  cfg_write,
  input  logic [SEL_W-1:0]      cfg_sel,
  input  logic [CNT_W-1:0]      cfg_div,
  input  logic [CNT_W-1:0]      cfg_phase,
  output logic [NUM_CLOCKS-1:0] outclk,
  output logic [NUM_CLOCKS-1:0] tick,
  output logic                  locked
);

  localparam int unsigned LOCK_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, ALIGN, SETTLE, LOCKED} state_t;

  state_t             state;
  logic [LOCK_W-1:0]  lock_cnt;
  logic [CNT_W-1:0]   sh_div   [NUM_CLOCKS];
  logic [CNT_W-1:0]   sh_phase [NUM_CLOCKS];
  logic [CNT_W-1:0]   cnt      [NUM_CLOCKS];
  logic [CNT_W-1:0]   run_div  [NUM_CLOCKS];
  logic [CNT_W-1:0]   load_div [NUM_CLOCKS];
  logic [CNT_W-1:0]   load_ph  [NUM_CLOCKS];
  logic [CNT_W-1:0]   load_cnt [NUM_CLOCKS];
  logic [CNT_W-1:0]   run_nxt  [NUM_CLOCKS];
  logic               cfg_valid_c;

  assign cfg_valid_c = cfg_write && (32'(cfg_sel) < NUM_CLOCKS);

  // Clamp the raw shadow values into the load-time divider, phase and start count.
  always_comb begin
    for (int i = 0; i < NUM_CLOCKS; i++) begin
      load_div[i] = (sh_div[i] < CNT_W'(2)) ? CNT_W'(2) : sh_div[i];
      load_ph[i]  = (sh_phase[i] > (load_div[i] - CNT_W'(1))) ?
                    (load_div[i] - CNT_W'(1)) : sh_phase[i];
      load_cnt[i] = (load_ph[i] == '0) ? '0 : (load_div[i] - load_ph[i]);
      run_nxt[i]  = (cnt[i] >= (run_div[i] - CNT_W'(1))) ? '0 : (cnt[i] + CNT_W'(1));
    end
  end

  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      state    <= IDLE;
      lock_cnt <= '0;
      locked   <= 1'b0;
      outclk   <= '0;
      tick     <= '0;
      for (int i = 0; i < NUM_CLOCKS; i++) begin
        sh_div[i]   <= DIV_INIT[i*CNT_W +: CNT_W];
        sh_phase[i] <= PHASE_INIT[i*CNT_W +: CNT_W];
        cnt[i]      <= '0;
        run_div[i]  <= CNT_W'(2);
      end
    end else begin
      // Shadow writes land in every state; the running channels only see them via ALIGN.
      for (int i = 0; i < NUM_CLOCKS; i++) begin
        if (cfg_valid_c && (cfg_sel == SEL_W'(i))) begin
          sh_div[i]   <= cfg_div;
          sh_phase[i] <= cfg_phase;
        end
      end
      outclk <= '0;
      tick   <= '0;
      case (state)
        IDLE: begin
          locked <= 1'b0;
          if (enable) state <= ALIGN;
        end
        ALIGN: begin
          locked <= 1'b0;
          if (!enable) begin
            state <= IDLE;
          end else begin
            state    <= SETTLE;
            lock_cnt <= '0;
            for (int i = 0; i < NUM_CLOCKS; i++) begin
              cnt[i]     <= load_cnt[i];
              run_div[i] <= load_div[i];
              outclk[i]  <= load_cnt[i] < (load_div[i] >> 1);
              tick[i]    <= load_cnt[i] == '0;
            end
          end
        end
        SETTLE, LOCKED: begin
          if (!enable) begin
            state  <= IDLE;
            locked <= 1'b0;
          end else if (resync || cfg_valid_c) begin
            state  <= ALIGN;
            locked <= 1'b0;
          end else begin
            for (int i = 0; i < NUM_CLOCKS; i++) begin
              cnt[i]    <= run_nxt[i];
              outclk[i] <= run_nxt[i] < (run_div[i] >> 1);
              tick[i]   <= run_nxt[i] == '0;
            end
            if (state == SETTLE) begin
              if (lock_cnt == LOCK_W'(LOCK_CYCLES - 1)) begin
                state  <= LOCKED;
                locked <= 1'b1;
              end else begin
                lock_cnt <= lock_cnt + LOCK_W'(1);
              end
            end
          end
        end
        default: begin
          state  <= IDLE;
          locked <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pyramic_clkdiv_gen.sv
// Bench for pyramic_clkdiv_gen: epoch-based timing model checked every cycle,
// plus directed literal checks; a 3-channel instance covers out-of-range cfg_sel.
module tb_pyramic_clkdiv_gen;

  logic        refclk = 1'b0;
  logic        rst_n, enable, resync, cfg_write;
  logic [1:0]  cfg_sel;
  logic [15:0] cfg_div, cfg_phase;
  logic [3:0]  outclk, tick;
  logic        locked;

  logic        s_rst_n, s_enable, s_resync, s_cfg_write;
  logic [1:0]  s_cfg_sel;
  logic [15:0] s_cfg_div, s_cfg_phase;
  logic [2:0]  s_outclk, s_tick;
  logic        s_locked;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  always #5 refclk = ~refclk;

  pyramic_clkdiv_gen dut (
    .refclk(refclk), .rst_n(rst_n), .enable(enable), .resync(resync),
    .cfg_write(cfg_write), .cfg_sel(cfg_sel), .cfg_div(cfg_div), .cfg_phase(cfg_phase),
    .outclk(outclk), .tick(tick), .locked(locked)
  );

  pyramic_clkdiv_gen #(
    .NUM_CLOCKS(3), .CNT_W(16), .SEL_W(2),
    .DIV_INIT({16'd4, 16'd2, 16'd2}), .PHASE_INIT({16'd0, 16'd1, 16'd0}),
    .LOCK_CYCLES(16)
  ) dut3 (
    .refclk(refclk), .rst_n(s_rst_n), .enable(s_enable), .resync(s_resync),
    .cfg_write(s_cfg_write), .cfg_sel(s_cfg_sel), .cfg_div(s_cfg_div), .cfg_phase(s_cfg_phase),
    .outclk(s_outclk), .tick(s_tick), .locked(s_locked)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Model: mode 0 idle, 1 align, 2 running since epoch t0 with captured div/phase.
  int cyc = 0, t0 = 0, mmode = 0;
  int sh_d[4], sh_p[4], ed[4], ep[4];
  bit mvalid;
  const int init_d[4] = '{2, 2, 4, 8};
  const int init_p[4] = '{0, 1, 0, 0};

  always @(posedge refclk) begin
    cyc++;
    if (!rst_n) begin
      mmode = 0;
      for (int i = 0; i < 4; i++) begin
        sh_d[i] = init_d[i];
        sh_p[i] = init_p[i];
      end
    end else begin
      mvalid = cfg_write && (int'(cfg_sel) < 4);
      case (mmode)
        0: if (enable) mmode = 1;
        1: if (!enable) mmode = 0;
           else begin
             mmode = 2;
             t0 = cyc;
             for (int i = 0; i < 4; i++) begin
               ed[i] = (sh_d[i] < 2) ? 2 : sh_d[i];
               ep[i] = (sh_p[i] > ed[i] - 1) ? ed[i] - 1 : sh_p[i];
             end
           end
        default: if (!enable) mmode = 0;
                 else if (resync || mvalid) mmode = 1;
      endcase
      if (mvalid) begin
        sh_d[cfg_sel] = int'(cfg_div);
        sh_p[cfg_sel] = int'(cfg_phase);
      end
    end
  end

  // Every cycle: channel i ticks at t0+ep+n*ed and is high for the first ed/2 cycles of each period.
  always @(negedge refclk) begin
    logic [3:0] eo, et;
    logic       el;
    int         k, pos;
    eo = '0; et = '0; el = 1'b0;
    if (mmode == 2) begin
      k = cyc - t0;
      el = (k >= 16);
      for (int i = 0; i < 4; i++) begin
        pos = (k + ed[i] - ep[i]) % ed[i];
        et[i] = (pos == 0);
        eo[i] = (pos < ed[i] / 2);
      end
    end
    if (chk_en) begin
      chk("model_outclk", 32'(outclk), 32'(eo));
      chk("model_tick", 32'(tick), 32'(et));
      chk("model_locked", 32'(locked), 32'(el));
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge refclk);
  endtask

  task automatic wr(input logic [1:0] sel, input logic [15:0] d, input logic [15:0] p);
    cfg_write = 1'b1; cfg_sel = sel; cfg_div = d; cfg_phase = p;
    step(1);
    cfg_write = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; resync = 1'b0; cfg_write = 1'b0;
    cfg_sel = '0; cfg_div = '0; cfg_phase = '0;
    s_rst_n = 1'b0; s_enable = 1'b0; s_resync = 1'b0; s_cfg_write = 1'b0;
    s_cfg_sel = '0; s_cfg_div = '0; s_cfg_phase = '0;
    step(2);
    chk_en = 1'b1;
    chk("reset_outclk", 32'(outclk), 32'h0);
    chk("reset_locked", 32'(locked), 32'h0);

    // Defaults from reset release
    rst_n = 1'b1; enable = 1'b1;
    step(1); chk("align_outclk", 32'(outclk), 32'h0);
    step(1); chk("t0_outclk", 32'(outclk), 32'hd); chk("t0_tick", 32'(tick), 32'hd);
    step(1); chk("t1_outclk", 32'(outclk), 32'he); chk("t1_tick", 32'(tick), 32'h2);
    step(14); chk("t15_locked", 32'(locked), 32'h0);
    step(1); chk("t16_locked", 32'(locked), 32'h1);
    step(8);

    // Reprogram ch2 to div 5 phase 3 while locked
    wr(2'd2, 16'd5, 16'd3);
    chk("wr_align_locked", 32'(locked), 32'h0);
    chk("wr_align_outclk", 32'(outclk), 32'h0);
    step(1); chk("c2_t0_tick", 32'(tick[2]), 32'h0);
    step(3); chk("c2_t3_tick", 32'(tick[2]), 32'h1); chk("c2_t3_clk", 32'(outclk[2]), 32'h1);
    step(1); chk("c2_t4_clk", 32'(outclk[2]), 32'h1);
    step(1); chk("c2_t5_clk", 32'(outclk[2]), 32'h0);
    step(3); chk("c2_t8_tick", 32'(tick[2]), 32'h1);
    step(30);

    // Clamping: div 0 and div 1 behave as div 2; phase 9 on div 4 becomes 3
    wr(2'd3, 16'd0, 16'd0);
    step(1); chk("div0_t0_tick", 32'(tick[3]), 32'h1);
    step(2); chk("div0_t2_tick", 32'(tick[3]), 32'h1);
    step(20);
    wr(2'd3, 16'd1, 16'd0);
    step(5);
    wr(2'd2, 16'd4, 16'd9);
    step(1); chk("ph9_t0_clk", 32'(outclk[2]), 32'h1); chk("ph9_t0_tick", 32'(tick[2]), 32'h0);
    step(2); chk("ph9_t2_tick", 32'(tick[2]), 32'h0);
    step(1); chk("ph9_t3_tick", 32'(tick[2]), 32'h1);
    step(20);
    // Write landing in ALIGN is stored only; it is loaded at the next realign
    wr(2'd1, 16'd3, 16'd0);
    wr(2'd1, 16'd4, 16'd1);
    step(12);

    // Resync, then drop enable at T0+5
    resync = 1'b1; step(1); resync = 1'b0;
    step(1); step(5);
    enable = 1'b0;
    step(1);
    chk("dis_outclk", 32'(outclk), 32'h0);
    chk("dis_tick", 32'(tick), 32'h0);
    chk("dis_locked", 32'(locked), 32'h0);
    step(3);
    enable = 1'b1;
    step(2); step(15); chk("reen_t15_locked", 32'(locked), 32'h0);
    step(1); chk("reen_t16_locked", 32'(locked), 32'h1);
    step(4);

    // Resync together with a ch0 write: one ALIGN using div 6
    resync = 1'b1; cfg_write = 1'b1; cfg_sel = 2'd0; cfg_div = 16'd6; cfg_phase = 16'd0;
    step(1);
    resync = 1'b0; cfg_write = 1'b0;
    chk("rw_align_outclk", 32'(outclk), 32'h0);
    step(1); chk("rw_t0_tick", 32'(tick[0]), 32'h1);
    step(1); chk("rw_t1_tick", 32'(tick[0]), 32'h0); chk("rw_t1_clk", 32'(outclk[0]), 32'h1);
    step(2); chk("rw_t3_clk", 32'(outclk[0]), 32'h0);
    step(3); chk("rw_t6_tick", 32'(tick[0]), 32'h1);
    step(20);

    // One-cycle reset mid-LOCKED restores defaults
    rst_n = 1'b0; step(1);
    chk("rst_outclk", 32'(outclk), 32'h0);
    chk("rst_locked", 32'(locked), 32'h0);
    rst_n = 1'b1;
    step(1); step(1);
    chk("rst_t0_outclk", 32'(outclk), 32'hd); chk("rst_t0_tick", 32'(tick), 32'hd);
    step(16); chk("rst_t16_locked", 32'(locked), 32'h1);
    step(10);

    // 3-channel instance: cfg_sel=3 is ignored
    s_rst_n = 1'b1; s_enable = 1'b1;
    step(2); step(20);
    chk("n3_locked", 32'(s_locked), 32'h1);
    chk("n3_t20_tick0", 32'(s_tick[0]), 32'h1);
    s_cfg_write = 1'b1; s_cfg_sel = 2'd3; s_cfg_div = 16'd7; s_cfg_phase = 16'd0;
    step(1);
    s_cfg_write = 1'b0;
    chk("n3_sel3_locked", 32'(s_locked), 32'h1);
    chk("n3_t21_tick0", 32'(s_tick[0]), 32'h0);
    step(1);
    chk("n3_t22_tick0", 32'(s_tick[0]), 32'h1);
    chk("n3_t22_locked", 32'(s_locked), 32'h1);
    step(1);
    chk("n3_t23_tick1", 32'(s_tick[1]), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pyramic_clkdiv_gen.md
Name: pyramic_clkdiv_gen

Overview:
Parametrised multi-channel clock/strobe generator that derives NUM_CLOCKS divided clocks from one reference clock.
- Each channel has a runtime-programmable integer divider and phase offset.
- All channels are aligned to a common epoch and a lock indication is produced.
- It sits beside the fabric PLL and feeds the mic-array bit clocks and sample strobes. Dividers can be reprogrammed without re-locking the PLL.

Parameters:
NUM_CLOCKS, 4, number of output channels (1..16)
CNT_W, 16, width of divider/phase/counter fields
SEL_W, 2, width of cfg_sel; 2**SEL_W >= NUM_CLOCKS
DIV_INIT, {16'd8,16'd4,16'd2,16'd2}, packed reset dividers; channel i at bits [i*CNT_W +: CNT_W]
PHASE_INIT, {16'd0,16'd0,16'd1,16'd0}, packed reset phase offsets in refclk cycles, same packing
LOCK_CYCLES, 16, SETTLE cycles before locked asserts (>=1)

Ports:
refclk  in  1  sole clock; all logic on rising edge
rst_n  in  1  synchronous active-low reset
enable  in  1  run request; low parks all channels
resync  in  1  single-cycle pulse; realign all channels
cfg_write  in  1  write strobe for the per-channel shadow config
cfg_sel  in  SEL_W  channel index for cfg_write
cfg_div  in  CNT_W  new divider
cfg_phase  in  CNT_W  new phase offset
outclk  out  NUM_CLOCKS  registered divided clocks
tick  out  NUM_CLOCKS  one-cycle pulse coincident with each outclk rising cycle
locked  out  1  all channels aligned and settled

Behaviour:
- Reset (rst_n=0 at an edge):
  - state=IDLE; outclk=0, tick=0, locked=0.
  - Shadow div/phase reload from DIV_INIT/PHASE_INIT; lock counter=0.
- Shadow config:
  - Effective div = max(shadow_div, 2).
  - Effective phase = min(shadow_phase, div-1).
  - Clamping is applied at load time; shadow stores the raw value.
- FSM states: IDLE, ALIGN, SETTLE, LOCKED.
  - IDLE: outputs 0. enable=1 -> ALIGN.
  - ALIGN: lasts exactly 1 cycle; outputs 0, locked=0. Next edge loads each channel cnt=(div-phase) mod div, then -> SETTLE.
  - SETTLE: channels run; locked=0. Lock counter counts from 0; after LOCK_CYCLES cycles in SETTLE -> LOCKED.
  - LOCKED: channels run; locked=1.
  - Any state except IDLE: enable=0 -> IDLE at next edge (outputs 0 that cycle on).
  - SETTLE/LOCKED: resync=1 or a valid cfg_write -> ALIGN at next edge; locked drops the same edge.
- Channel counter:
  - Increments every cycle in SETTLE/LOCKED; wraps from div-1 to 0.
  - outclk register = (cnt < floor(div/2)) and tick register = (cnt == 0), both computed from the next cnt value, so they are glitch-free registered outputs.
  - Odd div: high floor(div/2) cycles, low ceil(div/2) cycles.
- Timing: T0 = first cycle in SETTLE.
  - Channel with phase p has its first tick/rising outclk at T0+p, then every div cycles.
  - locked first high at T0+LOCK_CYCLES.
  - Latency enable-high in IDLE to T0 is 2 edges.
- cfg_write:
  - Updates shadow[cfg_sel] at the edge in any state, including IDLE and ALIGN.
  - cfg_sel >= NUM_CLOCKS: ignored entirely, no realign.
  - In IDLE/ALIGN: stored only; the next/current ALIGN load uses the new value if the write edge precedes the load edge.
- Simultaneous events:
  - resync together with cfg_write -> a single ALIGN using the new value.
  - enable=0 overrides resync/cfg_write; shadow still updates.
  - rst_n=0 overrides everything, mid-operation included.
- Counters are never observable outside 0..div-1; a divider change only takes effect through ALIGN, never mid-period.

Test Plan:
- Defaults, enable=1 from reset release:
  - ch0: period 2, tick at T0, T0+2…
  - ch1: div2 phase1, tick at T0+1.
  - ch2: period 4, high cycles T0, T0+1.
  - ch3: period 8, 4 high/4 low.
  - locked rises exactly at T0+16.
- cfg_write sel=2, div=5, phase=3 while LOCKED:
  - locked=0 next cycle; ALIGN 1 cycle.
  - ch2 tick at new T0+3, period 5, high 2/low 3.
  - Other channels realigned to the new T0.
- Clamping: cfg_div=0 then 1 -> ch behaves as div 2; cfg_phase=9 with div 4 -> phase 3 (tick at T0+3); cfg_sel=3 with NUM_CLOCKS=3 -> no state change, locked stays 1.
- enable dropped at T0+5 -> all outputs 0 next cycle, state IDLE; re-enable -> fresh ALIGN, T0 two edges later, locked after LOCK_CYCLES again.
- resync and cfg_write (sel=0, div=6) same cycle -> exactly one ALIGN cycle; ch0 period 6 from new T0.
- rst_n=0 mid-LOCKED for 1 cycle -> outputs 0, shadow back to DIV_INIT/PHASE_INIT; prior cfg_write values gone; default timings repeat.
